// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag layout, opcode/type encodings, line geometry and arbiter states.
package sysbus_pkg;

  localparam int TAG_W        = 13;
  localparam int TAG_WR_BIT   = 12;
  localparam int TAG_TYPE_LSB = 8;
  localparam int TAG_TYPE_W   = 4;
  localparam int TAG_ID_W     = 8;

  localparam int BEATS        = 8;
  localparam int LINE_OFS_W   = 6;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic [TAG_TYPE_W-1:0] TYPE_MEMORY = 4'h0;
  localparam logic [TAG_TYPE_W-1:0] TYPE_MMIO   = 4'h1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WAIT_RESP,
    RESP
  } arb_state_t;

  // Keep the requester's write/type fields and replace the id with the owning port.
  function automatic logic [TAG_W-1:0] stamp_id(input logic [TAG_W-1:0]    tag,
                                                input logic [TAG_ID_W-1:0] id);
    return {tag[TAG_W-1:TAG_ID_W], id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over a request vector; the search starts at the port after the last grant.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  input  logic [IDX_W-1:0] update_idx,
  output logic [IDX_W-1:0] pick,
  output logic             valid
);

  logic [IDX_W-1:0] rr_last;

  // Reset to the last port so that port 0 wins the first arbitration.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last <= IDX_W'(N_REQ - 1);
    end else if (update) begin
      rr_last <= update_idx;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!valid && req[(int'(rr_last) + k) % N_REQ]) begin
        valid = 1'b1;
        pick  = IDX_W'((int'(rr_last) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares the Sysbus master port between instruction fetch (port 0) and data/MMIO (port 1),
// one whole-line transaction at a time, routing response beats back to the owner.
module sysbus_arbiter
  import sysbus_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        cli_reqcyc,
  input  logic [N_REQ*DATA_W-1:0] cli_req,
  input  logic [N_REQ*TAG_W-1:0]  cli_reqtag,
  output logic [N_REQ-1:0]        cli_grant,
  output logic [N_REQ-1:0]        cli_wready,
  output logic [N_REQ-1:0]        cli_respcyc,
  output logic [DATA_W-1:0]       cli_resp,
  output logic [N_REQ-1:0]        cli_err,
  output logic                    bus_reqcyc,
  output logic [DATA_W-1:0]       bus_req,
  output logic [TAG_W-1:0]        bus_reqtag,
  input  logic                    bus_reqack,
  input  logic                    bus_respcyc,
  input  logic [DATA_W-1:0]       bus_resp,
  input  logic [TAG_W-1:0]        bus_resptag,
  output logic                    bus_respack
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [DATA_W-1:0] LINE_MASK = ~(DATA_W'((1 << LINE_OFS_W) - 1));
  localparam logic [3:0]        LAST_BEAT = 4'(BEATS - 1);
  localparam logic [3:0]        BEAT_MAX  = 4'(BEATS);

  arb_state_t         state, state_next;
  logic [IDX_W-1:0]   owner;
  logic [DATA_W-1:0]  addr_q;
  logic [TAG_W-1:0]   tag_q;
  logic [3:0]         beat_cnt;
  logic [TMR_W-1:0]   timer;

  logic               load, beat_clr, beat_inc, rr_update;
  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [DATA_W-1:0]  sel_req, owner_req;
  logic [TAG_W-1:0]   sel_tag;
  logic               id_match;

  logic               unused_resp_tag;
  assign unused_resp_tag = ^bus_resptag[TAG_W-1:TAG_ID_W];

  assign sel_req   = cli_req[int'(pick) * DATA_W +: DATA_W];
  assign sel_tag   = cli_reqtag[int'(pick) * TAG_W +: TAG_W];
  assign owner_req = cli_req[int'(owner) * DATA_W +: DATA_W];
  assign id_match  = (bus_resptag[TAG_ID_W-1:0] == tag_q[TAG_ID_W-1:0]);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (cli_reqcyc),
    .update    (rr_update),
    .update_idx(owner),
    .pick      (pick),
    .valid     (any_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      addr_q   <= '0;
      tag_q    <= '0;
      beat_cnt <= '0;
      timer    <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        owner  <= pick;
        addr_q <= sel_req & LINE_MASK;
        tag_q  <= stamp_id(sel_tag, TAG_ID_W'(pick));
      end
      // Beat counter saturates at a full line rather than wrapping.
      if (beat_clr) begin
        beat_cnt <= '0;
      end else if (beat_inc && beat_cnt != BEAT_MAX) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
      if (state == WAIT_RESP && state_next == WAIT_RESP) begin
        timer <= timer + TMR_W'(1);
      end else begin
        timer <= '0;
      end
    end
  end

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    beat_clr    = 1'b0;
    beat_inc    = 1'b0;
    rr_update   = 1'b0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    cli_grant   = '0;
    cli_wready  = '0;
    cli_respcyc = '0;
    cli_resp    = '0;
    cli_err     = '0;

    case (state)
      IDLE: begin
        if (any_req) begin
          load       = 1'b1;
          state_next = ADDR;
        end
      end

      ADDR: begin
        bus_reqcyc = 1'b1;
        bus_req    = addr_q;
        bus_reqtag = tag_q;
        if (bus_reqack) begin
          cli_grant[owner] = 1'b1;
          rr_update        = 1'b1;
          beat_clr         = 1'b1;
          state_next       = tag_q[TAG_WR_BIT] ? WDATA : WAIT_RESP;
        end
      end

      // Write data flows straight from the owner to the bus; the owner advances on reqack.
      WDATA: begin
        cli_wready[owner] = 1'b1;
        bus_reqcyc        = 1'b1;
        bus_req           = owner_req;
        bus_reqtag        = tag_q;
        if (bus_reqack) begin
          beat_inc = 1'b1;
          if (beat_cnt == LAST_BEAT) state_next = IDLE;
        end
      end

      // Beats carrying another id are acknowledged and dropped.
      WAIT_RESP: begin
        bus_respack = bus_respcyc;
        if (bus_respcyc && id_match) begin
          cli_respcyc[owner] = 1'b1;
          cli_resp           = bus_resp;
          beat_inc           = 1'b1;
          state_next         = RESP;
        end else if (timer == TMR_W'(TIMEOUT)) begin
          cli_err[owner] = 1'b1;
          state_next     = IDLE;
        end
      end

      RESP: begin
        bus_respack = bus_respcyc;
        if (bus_respcyc) begin
          cli_respcyc[owner] = 1'b1;
          cli_resp           = bus_resp;
          beat_inc           = 1'b1;
          if (beat_cnt == LAST_BEAT) state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(cli_grant));
  a_resp_onehot:  assert property (@(posedge clk) disable iff (!reset) $onehot0(cli_respcyc));
  a_no_req_in_resp: assert property (@(posedge clk) disable iff (!reset)
    (state == WAIT_RESP || state == RESP) |-> !bus_reqcyc);
  a_hold_until_grant: assert property (@(posedge clk) disable iff (!reset)
    (state == ADDR) |-> cli_reqcyc[owner]);

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: stimulus queues expected grants/beats/errors, a monitor checks them.
module tb_sysbus_arbiter;
  import sysbus_pkg::*;

  logic                 clk   = 1'b0;
  logic                 reset = 1'b0;
  logic [1:0]           cli_reqcyc  = '0;
  logic [127:0]         cli_req     = '0;
  logic [2*TAG_W-1:0]   cli_reqtag  = '0;
  logic [1:0]           cli_grant, cli_wready, cli_respcyc, cli_err;
  logic [63:0]          cli_resp;
  logic                 bus_reqcyc, bus_respack;
  logic [63:0]          bus_req;
  logic [TAG_W-1:0]     bus_reqtag;
  logic                 bus_reqack  = 1'b0;
  logic                 bus_respcyc = 1'b0;
  logic [63:0]          bus_resp    = '0;
  logic [TAG_W-1:0]     bus_resptag = '0;

  typedef enum int {EV_GRANT, EV_RESP, EV_WBEAT, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t         kind;
    int               port;
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  sysbus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cli_reqcyc (cli_reqcyc),
    .cli_req    (cli_req),
    .cli_reqtag (cli_reqtag),
    .cli_grant  (cli_grant),
    .cli_wready (cli_wready),
    .cli_respcyc(cli_respcyc),
    .cli_resp   (cli_resp),
    .cli_err    (cli_err),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TAG_W-1:0] mk_tag(input logic wr, input logic [3:0] typ,
                                              input logic [7:0] id);
    logic [TAG_W-1:0] t;
    t = TAG_W'(id);
    t[TAG_WR_BIT] = wr;
    t[TAG_TYPE_LSB +: TAG_TYPE_W] = typ;
    return t;
  endfunction

  function automatic void push_exp(input ev_kind_t k, input int p, input logic [63:0] d,
                                   input logic [TAG_W-1:0] t);
    ev_t e;
    e.kind = k;
    e.port = p;
    e.data = d;
    e.tag  = t;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input ev_kind_t k, input int p, input logic [63:0] d,
                         input logic [TAG_W-1:0] t);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL unexpected_event: got kind %0d port %0d data %h, expected none", k, p, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(k), 64'(e.kind));
      check("event_port", 64'(p), 64'(e.port));
      check("event_data", d, e.data);
      check("event_tag", 64'(t), 64'(e.tag));
    end
  endtask

  // Monitor: any DUT-presented event is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      if (|cli_grant)   observe(EV_GRANT, cli_grant[1] ? 1 : 0, bus_req, bus_reqtag);
      if (|cli_respcyc) observe(EV_RESP, cli_respcyc[1] ? 1 : 0, cli_resp, '0);
      if (|cli_err)     observe(EV_ERR, cli_err[1] ? 1 : 0, '0, '0);
      if (|cli_wready && bus_reqack) observe(EV_WBEAT, cli_wready[1] ? 1 : 0, bus_req, '0);
    end
  end

  task automatic set_req(input int p, input logic [63:0] a, input logic [TAG_W-1:0] t);
    cli_req[p*64 +: 64]         = a;
    cli_reqtag[p*TAG_W +: TAG_W] = t;
    cli_reqcyc[p]               = 1'b1;
  endtask

  // Bus side of the address phase: wait for reqcyc, hold off ack for 'delay' cycles, then ack.
  task automatic serve_addr(input int p, input int delay, input logic [63:0] ea,
                            input logic [TAG_W-1:0] et);
    int n;
    n = 0;
    push_exp(EV_GRANT, p, ea, et);
    #1;
    while (bus_reqcyc !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("addr_phase_seen", 64'(bus_reqcyc), 64'd1);
    for (int i = 0; i < delay; i++) begin
      check("addr_held", bus_req, ea);
      check("tag_held", 64'(bus_reqtag), 64'(et));
      check("no_early_grant", 64'(cli_grant), 64'd0);
      tick();
      #1;
    end
    bus_reqack = 1'b1;
    tick();
    bus_reqack    = 1'b0;
    cli_reqcyc[p] = 1'b0;
    #1;
    check("grant_single_cycle", 64'(cli_grant), 64'd0);
  endtask

  task automatic respond(input int p, input logic [7:0] id, input int nb, input int gap_at,
                         input int gap_len, input logic [63:0] base);
    for (int i = 0; i < nb; i++) begin
      if (i == gap_at) begin
        bus_respcyc = 1'b0;
        repeat (gap_len) tick();
      end
      bus_respcyc = 1'b1;
      bus_resptag = mk_tag(OP_READ, TYPE_MEMORY, id);
      bus_resp    = base + 64'(i);
      push_exp(EV_RESP, p, base + 64'(i), '0);
      tick();
    end
    bus_respcyc = 1'b0;
  endtask

  initial begin
    int n;

    // Both requesters waiting across reset release: port 0 must win first.
    set_req(0, 64'h0000_0000_8000_0047, mk_tag(OP_READ, TYPE_MEMORY, 8'hFF));
    set_req(1, 64'h0000_0000_0000_1234, mk_tag(OP_READ, TYPE_MMIO, 8'hAA));
    repeat (3) tick();
    check("reset_outputs_zero", 64'(|{cli_grant, cli_wready, cli_respcyc, cli_resp, cli_err,
                                      bus_reqcyc, bus_req, bus_reqtag, bus_respack}), 64'd0);
    reset = 1'b1;

    serve_addr(0, 0, 64'h0000_0000_8000_0040, 13'h0000);
    respond(0, 8'h00, 8, 3, 2, 64'hC0DE_0000_0000_0000);
    #1;
    check("idle_after_read_line", 64'({bus_reqcyc, cli_respcyc}), 64'd0);

    // Port 1 next; address ack held off 5 cycles.
    serve_addr(1, 5, 64'h0000_0000_0000_1200, 13'h0101);
    set_req(1, 64'h0000_0000_2000_00A5, mk_tag(OP_WRITE, TYPE_MEMORY, 8'h3C));
    set_req(0, 64'h3000_0000_0000_0020, mk_tag(OP_READ, TYPE_MMIO, 8'h55));
    bus_respcyc = 1'b1;
    bus_resptag = mk_tag(OP_READ, TYPE_MEMORY, 8'h05);
    bus_resp    = 64'h0000_0000_0000_DEAD;
    #1;
    check("foreign_id_acked", 64'(bus_respack), 64'd1);
    check("foreign_id_dropped", 64'(cli_respcyc), 64'd0);
    tick();
    respond(1, 8'h01, 8, -1, 0, 64'h5151_0000_0000_0000);
    #1;
    check("idle_after_port1_line", 64'(bus_reqcyc), 64'd0);

    // Both pending, port 1 went last: port 0 wins; this read never gets a response.
    serve_addr(0, 1, 64'h3000_0000_0000_0000, 13'h0100);
    push_exp(EV_ERR, 0, '0, '0);
    n = 1;
    while (cli_err == 2'b00 && n < 1100) begin
      tick();
      #1;
      n++;
    end
    check("timeout_latency", 64'(n), 64'd1024);
    tick();
    #1;
    check("err_single_pulse", 64'(cli_err), 64'd0);
    check("idle_after_timeout", 64'(bus_reqcyc), 64'd0);

    // Port 1 line write with a one-cycle ack pause in the middle.
    serve_addr(1, 0, 64'h0000_0000_2000_0080, 13'h1001);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        bus_reqack = 1'b0;
        #1;
        check("wready_held_in_pause", 64'(cli_wready), 64'd2);
        tick();
      end
      cli_req[64 +: 64] = 64'hF00D_0000_0000_0000 + 64'(i) * 64'h1111;
      bus_reqack        = 1'b1;
      push_exp(EV_WBEAT, 1, 64'hF00D_0000_0000_0000 + 64'(i) * 64'h1111, '0);
      #1;
      check("wready_owner", 64'(cli_wready), 64'd2);
      tick();
    end
    bus_reqack = 1'b0;
    #1;
    check("idle_after_write", 64'({cli_wready, bus_reqcyc, bus_respack}), 64'd0);

    // Read interrupted by reset after the third beat.
    set_req(0, 64'h0000_0000_4000_0010, mk_tag(OP_READ, TYPE_MEMORY, 8'h77));
    serve_addr(0, 0, 64'h0000_0000_4000_0000, 13'h0000);
    respond(0, 8'h00, 3, -1, 0, 64'h7777_0000_0000_0000);
    bus_respcyc = 1'b1;
    bus_resptag = '0;
    bus_resp    = 64'h7777_0000_0000_0003;
    reset       = 1'b0;
    #1;
    check("abort_outputs_zero", 64'(|{cli_grant, cli_wready, cli_respcyc, cli_resp, cli_err,
                                      bus_reqcyc, bus_req, bus_reqtag, bus_respack}), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check("no_beat_after_reset", 64'({cli_respcyc, bus_respack}), 64'd0);
    tick();
    #1;
    check("still_idle_after_reset", 64'({cli_respcyc, bus_respack, bus_reqcyc}), 64'd0);
    bus_respcyc = 1'b0;

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single Sysbus master port between two requesters: port 0 = instruction fetch, port 1 = data memory/MMIO.
- Accepts one whole-line transaction at a time (address phase, write-data beats if any, 8 response beats) and routes responses back to the owning requester.
- Sits between the core's fetch/LSU front-ends and the Sysbus; owns reqcyc/req/reqtag/respack.

Parameters:
- N_REQ, 2, number of requesters (fixed 2 in this revision; index 0 highest priority on reset).
- DATA_W, 64, Sysbus beat width.
- TAG_W, 13, Sysbus tag width: [12] write, [11:8] type, [7:0] id.
- BEATS, 8, beats per line (64-byte line).
- TIMEOUT, 1023, cycles in WAIT_RESP before error.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- cli_reqcyc  in  N_REQ  per-requester request valid; held until cli_grant.
- cli_req  in  N_REQ*DATA_W  address (bits [5:0] ignored, forced 0); write data on later beats.
- cli_reqtag  in  N_REQ*TAG_W  write/type fields; id field overwritten by arbiter.
- cli_grant  out  N_REQ  one-hot pulse: address accepted by bus (mirrors reqack).
- cli_wready  out  N_REQ  owner may present the next write beat on cli_req.
- cli_respcyc  out  N_REQ  response beat valid for that requester.
- cli_resp  out  DATA_W  response data (shared, qualified by cli_respcyc).
- cli_err  out  N_REQ  one-cycle pulse: transaction aborted by timeout.
- bus_reqcyc  out  1  Sysbus request valid.
- bus_req  out  DATA_W  Sysbus address/write data.
- bus_reqtag  out  TAG_W  Sysbus tag.
- bus_reqack  in  1  Sysbus accepted address.
- bus_respcyc  in  1  Sysbus response beat valid.
- bus_resp  in  DATA_W  Sysbus response data.
- bus_resptag  in  TAG_W  Sysbus response tag.
- bus_respack  out  1  response beat accepted.

Behaviour:
- Reset (reset low, async): state=IDLE, rr_last=1 (so port 0 wins first), beat_cnt=0, timer=0. All outputs 0.
- States: IDLE, ADDR, WDATA, WAIT_RESP, RESP.
- IDLE: if any cli_reqcyc, pick owner round-robin (the port after rr_last wins on a tie); register owner, address&~63, tag with id[7:0]=owner. Next cycle: ADDR. Arbitration decision costs 1 cycle; a request is never sampled while not IDLE.
- ADDR: bus_reqcyc=1, bus_req/bus_reqtag stable until bus_reqack. On bus_reqack: cli_grant[owner] pulses the same cycle; rr_last<=owner; write tag -> WDATA (beat_cnt=0) else WAIT_RESP.
- WDATA: cli_wready[owner]=1; bus_reqcyc=1, bus_req=cli_req[owner] combinationally; each cycle bus_reqack=1 counts one beat; after BEATS beats -> IDLE (writes expect no response).
- WAIT_RESP: bus_respack=bus_respcyc. First bus_respcyc with bus_resptag[7:0]==owner -> RESP, beat is forwarded that cycle. Beats with a non-matching id are acked and dropped.
- RESP: forward each bus_respcyc beat as cli_respcyc[owner]=1, cli_resp=bus_resp, same cycle (zero latency). After BEATS beats (counting the first) -> IDLE. A gap cycle in respcyc inside a line is legal and does not end RESP.
- Timeout: timer counts cycles in WAIT_RESP; when it reaches TIMEOUT, pulse cli_err[owner] and go to IDLE. Timer clears on leaving WAIT_RESP.
- beat_cnt is 4 bits and saturates at BEATS; it never wraps.
- A requester dropping cli_reqcyc after arbitration but before grant does not cancel the transaction (protocol violation; assertion).
- Asynchronous reset in any state aborts immediately; no partial beats are delivered after reset release.
- Assertions: cli_grant and cli_respcyc are one-hot-or-zero; bus_reqcyc is never 1 in WAIT_RESP/RESP.

Decomposition:
- sysbus_pkg: TAG_W, field offsets, READ/WRITE and MEMORY/MMIO encodings, BEATS, state enum type arb_state_t.
- Sub-module rr_arbiter (N_REQ-wide round-robin pick from request vector and rr_last; combinational with registered last-grant).

Test Plan:
- Reset with both cli_reqcyc high -> port 0 granted first; once its 8 beats complete, port 1 is granted; third request from 0 while 1 is also pending -> port 0 (alternation holds).
- Port 1 read at 0x1234 with bus_reqack delayed 5 cycles -> bus_req=0x1200 held stable, tag id=1, cli_grant[1] pulses on the ack cycle only.
- Read response with a 2-cycle gap between beats 3 and 4 -> 8 cli_respcyc[0] pulses, data in order, return to IDLE after beat 8.
- Response beat with id=5 arriving in WAIT_RESP -> bus_respack=1, no cli_respcyc; the matching beats that follow are delivered normally.
- Port 1 write (tag[12]=1) -> 8 data beats on bus_req equal the cli_req values presented while cli_wready=1; returns to IDLE with no RESP.
- No response for TIMEOUT cycles -> cli_err[owner] pulses once, state IDLE; reset asserted mid-RESP after beat 3 -> all outputs 0 immediately.
